pll_lock_ctrl: RTL and testbench

- Reset/lock sequencer for the LVDS-mode transceiver PLL (156.25 MHz ref -> 644.53125 MHz).
- Drives the PLL reset, qualifies its locked output, and retries on lock timeout.
- Monitors loss of lock and releases a downstream datapath-ready flag only after lock has been stable.
- Runs on the free-running reference clock, never on a PLL output.

---
 rtl/pll_lock_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// Reset/lock sequencer for the transceiver PLL. It pulses pll_rst, qualifies a
// synchronized pll_locked, retries on lock timeout and raises ready once lock is stable.
module pll_lock_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 7,
    parameter int CNT_W        = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             force_rst,
    output logic             pll_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] lol_cnt,
    output logic [2:0]       state
);

    localparam int RW = $clog2(RST_CYCLES);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0]    STB_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] MAX_R    = CNT_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           st;
    state_t           st_nxt;
    logic             lk_m;
    logic             lk_s;
    logic [RW-1:0]    rst_tmr;
    logic [RW-1:0]    rst_tmr_nxt;
    logic [TW-1:0]    tmo_tmr;
    logic [TW-1:0]    tmo_tmr_nxt;
    logic [SW-1:0]    stb_cnt;
    logic [SW-1:0]    stb_cnt_nxt;
    logic [CNT_W-1:0] retry_nxt;
    logic [CNT_W-1:0] retry_inc;
    logic [CNT_W-1:0] lol_nxt;
    logic             timeout;

    // pll_locked comes from the PLL's own clock domain
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    always_comb begin
        st_nxt      = st;
        rst_tmr_nxt = rst_tmr;
        tmo_tmr_nxt = tmo_tmr;
        stb_cnt_nxt = stb_cnt;
        retry_nxt   = retry_cnt;
        lol_nxt     = lol_cnt;
        timeout     = 1'b0;
        retry_inc   = retry_cnt + 1'b1;

        case (st)
            S_RESET: begin
                if (rst_tmr == RST_LAST) begin
                    st_nxt      = S_WAIT_LOCK;
                    rst_tmr_nxt = '0;
                end else begin
                    rst_tmr_nxt = rst_tmr + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                tmo_tmr_nxt = tmo_tmr + 1'b1;
                if (tmo_tmr == TMO_LAST) begin
                    timeout = 1'b1;
                end else if (lk_s) begin
                    st_nxt      = S_STABLE;
                    stb_cnt_nxt = '0;
                end
            end
            S_STABLE: begin
                tmo_tmr_nxt = tmo_tmr + 1'b1;
                // Qualification finishing on the timeout cycle still counts as lock
                if (lk_s && (stb_cnt == STB_LAST)) begin
                    st_nxt    = S_RUN;
                    retry_nxt = '0;
                end else if (tmo_tmr == TMO_LAST) begin
                    timeout = 1'b1;
                end else if (!lk_s) begin
                    st_nxt = S_WAIT_LOCK;
                end else begin
                    stb_cnt_nxt = stb_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lk_s) begin
                    st_nxt = S_RESET;
                    if (lol_cnt != '1) begin
                        lol_nxt = lol_cnt + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                st_nxt = S_FAULT;
            end
            default: begin
                st_nxt = S_RESET;
            end
        endcase

        if (timeout) begin
            retry_nxt = retry_inc;
            st_nxt    = (retry_inc == MAX_R) ? S_FAULT : S_RESET;
        end

        if (force_rst) begin
            st_nxt    = S_RESET;
            retry_nxt = '0;
        end

        // Every entry into RESET, including re-entry under force_rst, restarts the pulse
        if ((st_nxt == S_RESET) && ((st != S_RESET) || force_rst)) begin
            rst_tmr_nxt = '0;
        end
        // The lock timer spans WAIT_LOCK and STABLE together and is idle elsewhere
        if ((st_nxt != S_WAIT_LOCK) && (st_nxt != S_STABLE)) begin
            tmo_tmr_nxt = '0;
        end
        if (st_nxt != S_STABLE) begin
            stb_cnt_nxt = '0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_RESET;
            rst_tmr   <= '0;
            tmo_tmr   <= '0;
            stb_cnt   <= '0;
            retry_cnt <= '0;
            lol_cnt   <= '0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            st        <= st_nxt;
            rst_tmr   <= rst_tmr_nxt;
            tmo_tmr   <= tmo_tmr_nxt;
            stb_cnt   <= stb_cnt_nxt;
            retry_cnt <= retry_nxt;
            lol_cnt   <= lol_nxt;
            pll_rst   <= (st_nxt == S_RESET) || (st_nxt == S_FAULT);
            ready     <= (st_nxt == S_RUN);
            fault     <= (st_nxt == S_FAULT);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: a default-sized instance and a shrunken instance
// (short timeout, 2-bit counters) driven through directed steps with random lock delays.
module tb_pll_lock_ctrl;

    localparam int A_RC = 16, A_LS = 1024, A_LT = 65536, A_MR = 7, A_CW = 8;
    localparam int B_RC = 16, B_LS = 64,   B_LT = 200,   B_MR = 3, B_CW = 2;

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic rst_n_a, rst_n_b, pll_locked, force_rst, use_b;

    logic            a_pll_rst, a_ready, a_fault;
    logic [A_CW-1:0] a_retry, a_lol;
    logic [2:0]      a_state;
    logic            b_pll_rst, b_ready, b_fault;
    logic [B_CW-1:0] b_retry, b_lol;
    logic [2:0]      b_state;

    pll_lock_ctrl #(
        .RST_CYCLES(A_RC), .LOCK_STABLE(A_LS), .LOCK_TIMEOUT(A_LT),
        .MAX_RETRY(A_MR), .CNT_W(A_CW)
    ) dut_a (
        .refclk(refclk), .rst_n(rst_n_a), .pll_locked(pll_locked), .force_rst(force_rst),
        .pll_rst(a_pll_rst), .ready(a_ready), .fault(a_fault),
        .retry_cnt(a_retry), .lol_cnt(a_lol), .state(a_state)
    );

    pll_lock_ctrl #(
        .RST_CYCLES(B_RC), .LOCK_STABLE(B_LS), .LOCK_TIMEOUT(B_LT),
        .MAX_RETRY(B_MR), .CNT_W(B_CW)
    ) dut_b (
        .refclk(refclk), .rst_n(rst_n_b), .pll_locked(pll_locked), .force_rst(force_rst),
        .pll_rst(b_pll_rst), .ready(b_ready), .fault(b_fault),
        .retry_cnt(b_retry), .lol_cnt(b_lol), .state(b_state)
    );

    // View of whichever instance is under test
    logic       o_pll_rst, o_ready, o_fault;
    logic [7:0] o_retry, o_lol;
    logic [2:0] o_state;
    always_comb begin
        o_pll_rst = use_b ? b_pll_rst : a_pll_rst;
        o_ready   = use_b ? b_ready : a_ready;
        o_fault   = use_b ? b_fault : a_fault;
        o_retry   = use_b ? {6'b0, b_retry} : a_retry;
        o_lol     = use_b ? {6'b0, b_lol} : a_lol;
        o_state   = use_b ? b_state : a_state;
    end

    int tests = 0;
    int fails = 0;
    int cur_rc, cur_ls, cur_lt, cur_mr, lol_max, lol_exp, retry_exp;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        check("inv_ready_and_pll_rst", int'(o_ready & o_pll_rst), 0);
        check("inv_ready_outside_run", int'(o_ready && (o_state != 3'd3)), 0);
        check("inv_fault_outside_fault", int'(o_fault && (o_state != 3'd4)), 0);
    endtask

    // which: 0 = pll_rst, 1 = ready; n = ticks until the output shows val
    task automatic wait_for(input int which, input logic val, input int budget,
                            input string tag, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            n++;
            if (((which == 0) ? o_pll_rst : o_ready) == val) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, int'(seen), 1);
    endtask

    // Lock is declared after two synchronizer flops, one cycle for WAIT_LOCK to
    // see it, then LOCK_STABLE qualified cycles.
    function automatic int ready_latency(input int d);
        return d + 2 + 1 + cur_ls;
    endfunction

    task automatic expect_reset(input string tag);
        check({tag, "_state"}, int'(o_state), 0);
        check({tag, "_pll_rst"}, int'(o_pll_rst), 1);
        check({tag, "_ready"}, int'(o_ready), 0);
        check({tag, "_fault"}, int'(o_fault), 0);
        check({tag, "_retry"}, int'(o_retry), 0);
        check({tag, "_lol"}, int'(o_lol), 0);
    endtask

    // Called on the first tick with pll_rst low; raises pll_locked after d ticks
    task automatic lock_and_wait(input int d, input string tag);
        int n;
        repeat (d) tick();
        pll_locked = 1'b1;
        exp_q.push_back(32'(ready_latency(d)));
        wait_for(1, 1'b1, cur_ls + 64, tag, n);
        retry_exp = 0;
        check({tag, "_latency"}, d + n, int'(exp_q.pop_front()));
        check({tag, "_state"}, int'(o_state), 3);
        check({tag, "_retry"}, int'(o_retry), retry_exp);
        check({tag, "_pll_rst"}, int'(o_pll_rst), 0);
    endtask

    // Called in RUN; ends on the first tick with pll_rst low again
    task automatic lose_lock(input string tag);
        int n;
        pll_locked = 1'b0;
        wait_for(1, 1'b0, 10, {tag, "_ready_fall"}, n);
        check({tag, "_ready_fall_lat"}, n, 3);
        check({tag, "_pll_rst_up"}, int'(o_pll_rst), 1);
        lol_exp = (lol_exp < lol_max) ? lol_exp + 1 : lol_exp;
        check({tag, "_lol"}, int'(o_lol), lol_exp);
        check({tag, "_retry"}, int'(o_retry), retry_exp);
        wait_for(0, 1'b0, 40, {tag, "_pulse"}, n);
        check({tag, "_pulse_len"}, n, cur_rc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, d, k, elapsed;
        rst_n_a = 1'b0; rst_n_b = 1'b0; pll_locked = 1'b0; force_rst = 1'b0; use_b = 1'b0;
        cur_rc = A_RC; cur_ls = A_LS; cur_lt = A_LT; cur_mr = A_MR;
        lol_max = (1 << A_CW) - 1; lol_exp = 0; retry_exp = 0;

        // ---------------- instance A: default parameters ----------------
        repeat (3) tick();
        expect_reset("a_por");
        rst_n_a = 1'b1;
        wait_for(0, 1'b0, 64, "a_first_pulse", n);
        check("a_first_pulse_len", n, cur_rc);
        lock_and_wait(100, "a_lock100");

        for (int i = 0; i < 3; i++) begin
            lose_lock("a_lol");
            lock_and_wait(int'($urandom_range(0, 300)), "a_relock");
        end

        // Glitch at stable count 500: drop for 5 cycles, then a full requalification
        lose_lock("a_pre_glitch");
        d = int'($urandom_range(0, 200));
        repeat (d) tick();
        pll_locked = 1'b1;
        repeat (3 + 500) tick();
        check("a_glitch_in_stable", int'(o_state), 2);
        pll_locked = 1'b0;
        repeat (5) tick();
        check("a_glitch_back_to_wait", int'(o_state), 1);
        pll_locked = 1'b1;
        exp_q.push_back(32'(ready_latency(0)));
        wait_for(1, 1'b1, cur_ls + 64, "a_glitch_ready", n);
        check("a_glitch_latency", n, int'(exp_q.pop_front()));
        check("a_glitch_lol", int'(o_lol), lol_exp);

        // Asynchronous reset while in RUN, then while in STABLE
        @(negedge refclk);
        rst_n_a = 1'b0;
        #1;
        lol_exp = 0; retry_exp = 0;
        expect_reset("a_rst_in_run");
        tick();
        rst_n_a = 1'b1;
        wait_for(0, 1'b0, 64, "a_post_rst_pulse", n);
        check("a_post_rst_pulse_len", n, cur_rc);
        k = int'($urandom_range(10, 500));
        repeat (k) tick();
        check("a_stable_before_rst", int'(o_state), 2);
        @(negedge refclk);
        rst_n_a = 1'b0;
        #1;
        expect_reset("a_rst_in_stable");
        pll_locked = 1'b0;

        // ---------------- instance B: short timeout, 2-bit counters ----------------
        use_b = 1'b1;
        cur_rc = B_RC; cur_ls = B_LS; cur_lt = B_LT; cur_mr = B_MR;
        lol_max = (1 << B_CW) - 1; lol_exp = 0; retry_exp = 0;
        tick();
        expect_reset("b_por");
        rst_n_b = 1'b1;
        wait_for(0, 1'b0, 64, "b_first_pulse", n);
        check("b_first_pulse_len", n, cur_rc);
        lock_and_wait(int'($urandom_range(0, 100)), "b_lock");

        for (int i = 0; i < 5; i++) begin
            lose_lock("b_lol_sat");
            lock_and_wait(int'($urandom_range(0, 100)), "b_relock");
        end

        // A glitch in STABLE must not restart the lock timer
        lose_lock("b_cont");
        repeat (100) tick();
        pll_locked = 1'b1;
        repeat (3 + 60) tick();
        check("b_cont_stable", int'(o_state), 2);
        pll_locked = 1'b0;
        repeat (5) tick();
        pll_locked = 1'b1;
        elapsed = 100 + 63 + 5;
        wait_for(0, 1'b1, 100, "b_cont_timeout", n);
        check("b_cont_timeout_at", elapsed + n, cur_lt);
        retry_exp++;
        check("b_cont_retry", int'(o_retry), retry_exp);
        check("b_cont_ready", int'(o_ready), 0);
        check("b_cont_state", int'(o_state), 0);
        pll_locked = 1'b0;

        // Qualification completing on the timeout cycle wins; one cycle later loses
        wait_for(0, 1'b0, 64, "b_tie_pulse", n);
        check("b_tie_pulse_len", n, cur_rc);
        lock_and_wait(cur_lt - cur_ls - 3, "b_tie_completion");
        lose_lock("b_late");
        repeat (cur_lt - cur_ls - 2) tick();
        pll_locked = 1'b1;
        wait_for(0, 1'b1, cur_ls + 64, "b_late_timeout", n);
        check("b_late_timeout_at", (cur_lt - cur_ls - 2) + n, cur_lt);
        retry_exp++;
        check("b_late_retry", int'(o_retry), retry_exp);
        check("b_late_ready", int'(o_ready), 0);
        pll_locked = 1'b0;

        // Never locks: pulses spaced by the timeout until retries run out
        while (retry_exp < cur_mr) begin
            wait_for(0, 1'b0, 64, "b_retry_pulse", n);
            check("b_retry_pulse_len", n, cur_rc);
            wait_for(0, 1'b1, cur_lt + 64, "b_retry_gap", n);
            check("b_retry_gap_len", n, cur_lt);
            retry_exp++;
            check("b_retry_cnt", int'(o_retry), retry_exp);
            check("b_retry_fault", int'(o_fault), (retry_exp == cur_mr) ? 1 : 0);
            check("b_retry_state", int'(o_state), (retry_exp == cur_mr) ? 4 : 0);
        end
        repeat (50) tick();
        check("b_fault_hold", int'(o_fault), 1);
        check("b_fault_pll_rst", int'(o_pll_rst), 1);
        check("b_fault_state", int'(o_state), 4);
        check("b_fault_retry", int'(o_retry), cur_mr);

        // One-cycle force_rst clears the fault and restarts the sequence
        force_rst = 1'b1;
        tick();
        force_rst = 1'b0;
        retry_exp = 0;
        check("b_force_fault", int'(o_fault), 0);
        check("b_force_retry", int'(o_retry), retry_exp);
        check("b_force_state", int'(o_state), 0);
        check("b_force_pll_rst", int'(o_pll_rst), 1);
        wait_for(0, 1'b0, 64, "b_force_pulse", n);
        check("b_force_pulse_len", n, cur_rc);
        lock_and_wait(int'($urandom_range(0, 100)), "b_recover");
        check("b_recover_lol", int'(o_lol), lol_exp);

        // force_rst held for several cycles while locked
        k = int'($urandom_range(2, 8));
        force_rst = 1'b1;
        tick();
        check("b_held_ready", int'(o_ready), 0);
        check("b_held_state", int'(o_state), 0);
        check("b_held_pll_rst", int'(o_pll_rst), 1);
        repeat (k - 1) tick();
        check("b_held_pll_rst_still", int'(o_pll_rst), 1);
        force_rst = 1'b0;
        wait_for(0, 1'b0, 64, "b_held_pulse", n);
        check("b_held_pulse_len", n, cur_rc);
        exp_q.push_back(32'(1 + cur_ls));
        wait_for(1, 1'b1, cur_ls + 64, "b_held_relock", n);
        check("b_held_relock_latency", n, int'(exp_q.pop_front()));
        check("b_held_lol", int'(o_lol), lol_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
